// File: rtl/icache_pkg.sv
// Shared types and address-field width helpers for the direct-mapped instruction cache.
package icache_pkg;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_REFILL = 1'b1
    } state_t;

    localparam int ADDR_W = 32;

    function automatic int off_width(input int line_words);
        return $clog2(line_words);
    endfunction

    function automatic int idx_width(input int lines);
        return $clog2(lines);
    endfunction

    // Byte-offset bits [1:0] are never part of the tag.
    function automatic int tag_width(input int lines, input int line_words);
        return ADDR_W - $clog2(lines) - $clog2(line_words) - 2;
    endfunction

endpackage

// File: rtl/icache_array.sv
// Valid bits, tag RAM and data RAM of the icache: async read by idx/off,
// sync write of word/tag/valid, single-cycle clear of all valid bits.
import icache_pkg::*;

module icache_array #(
    parameter int WIDTH      = 32,
    parameter int LINES      = 16,
    parameter int LINE_WORDS = 4,
    localparam int OFF_W     = off_width(LINE_WORDS),
    localparam int IDX_W     = idx_width(LINES),
    localparam int TAG_W     = tag_width(LINES, LINE_WORDS)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic [IDX_W-1:0] rd_idx,
    input  logic [OFF_W-1:0] rd_off,
    output logic             rd_valid,
    output logic [TAG_W-1:0] rd_tag,
    output logic [WIDTH-1:0] rd_data,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_idx,
    input  logic [OFF_W-1:0] wr_off,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             tag_we,
    input  logic [TAG_W-1:0] tag_wdata,
    input  logic             valid_set
);

    logic [LINES-1:0] valid;
    logic [TAG_W-1:0] tags [LINES];
    logic [WIDTH-1:0] data [LINES*LINE_WORDS];

    // A clear in the same cycle as a tag write wins, so that line stays invalid.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            valid <= '0;
        end else if (tag_we) begin
            valid[wr_idx] <= valid_set;
        end
    end

    always_ff @(posedge clk) begin
        if (tag_we) begin
            tags[wr_idx] <= tag_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            data[{wr_idx, wr_off}] <= wr_data;
        end
    end

    assign rd_valid = valid[rd_idx];
    assign rd_tag   = tags[rd_idx];
    assign rd_data  = data[{rd_idx, rd_off}];

endmodule

// File: rtl/icache.sv
// Direct-mapped blocking instruction cache with word-by-word line refill over req/ack.
// Optional hit/miss counters are built when ICACHE_STATS_EN is defined.
import icache_pkg::*;

module icache #(
    parameter int WIDTH      = 32,
    parameter int LINES      = 16,
    parameter int LINE_WORDS = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cpu_req,
    input  logic [31:0]      cpu_addr,
    input  logic             cpu_flush,
    output logic [WIDTH-1:0] cpu_rdata,
    output logic             cpu_stall,
    output logic             mem_req,
    output logic [31:0]      mem_addr,
    input  logic             mem_ack,
    input  logic [WIDTH-1:0] mem_rdata
`ifdef ICACHE_STATS_EN
    ,
    output logic [31:0]      hit_count,
    output logic [31:0]      miss_count
`endif
);

    localparam int OFF_W = off_width(LINE_WORDS);
    localparam int IDX_W = idx_width(LINES);
    localparam int TAG_W = tag_width(LINES, LINE_WORDS);
    localparam int LA_W  = IDX_W + TAG_W;
    localparam logic [OFF_W-1:0] LAST_BEAT = OFF_W'(LINE_WORDS - 1);

    state_t           state;
    logic [OFF_W-1:0] beat;
    logic             flushed;
    logic [LA_W-1:0]  line_addr;

    logic [OFF_W-1:0] off;
    logic [IDX_W-1:0] idx;
    logic [TAG_W-1:0] tag;
    logic [1:0]       unused_byte_bits;

    logic             rd_valid;
    logic [TAG_W-1:0] rd_tag;
    logic [WIDTH-1:0] rd_data;

    logic             hit;
    logic             start_miss;
    logic             wr_en;
    logic             tag_we;

    assign off              = cpu_addr[OFF_W+1:2];
    assign idx              = cpu_addr[IDX_W+OFF_W+1:OFF_W+2];
    assign tag              = cpu_addr[31:IDX_W+OFF_W+2];
    assign unused_byte_bits = cpu_addr[1:0];

    assign hit        = cpu_req && rd_valid && (rd_tag == tag) && (state == ST_IDLE);
    assign cpu_stall  = cpu_req && !hit;
    assign cpu_rdata  = hit ? rd_data : '0;
    assign start_miss = (state == ST_IDLE) && cpu_req && !hit;

    // Writes target the latched line, never the live cpu_addr.
    assign wr_en  = !reset && (state == ST_REFILL) && mem_ack;
    assign tag_we = wr_en && (beat == LAST_BEAT);

    icache_array #(
        .WIDTH      (WIDTH),
        .LINES      (LINES),
        .LINE_WORDS (LINE_WORDS)
    ) u_array (
        .clk        (clk),
        .reset      (reset),
        .clear      (cpu_flush),
        .rd_idx     (idx),
        .rd_off     (off),
        .rd_valid   (rd_valid),
        .rd_tag     (rd_tag),
        .rd_data    (rd_data),
        .wr_en      (wr_en),
        .wr_idx     (line_addr[IDX_W-1:0]),
        .wr_off     (beat),
        .wr_data    (mem_rdata),
        .tag_we     (tag_we),
        .tag_wdata  (line_addr[LA_W-1:IDX_W]),
        .valid_set  (!flushed && !cpu_flush)
    );

    always_ff @(posedge clk) begin
        if (start_miss) begin
            line_addr <= cpu_addr[31:OFF_W+2];
        end
    end

    // flushed remembers a flush seen mid-refill so the finished line is not validated.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= ST_IDLE;
            beat     <= '0;
            mem_req  <= 1'b0;
            mem_addr <= '0;
            flushed  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start_miss) begin
                        beat     <= '0;
                        mem_req  <= 1'b1;
                        mem_addr <= {cpu_addr[31:OFF_W+2], (OFF_W+2)'(0)};
                        flushed  <= 1'b0;
                        state    <= ST_REFILL;
                    end
                end
                ST_REFILL: begin
                    if (cpu_flush) begin
                        flushed <= 1'b1;
                    end
                    if (mem_ack) begin
                        beat     <= beat + 1'b1;
                        mem_addr <= mem_addr + 32'd4;
                        if (beat == LAST_BEAT) begin
                            mem_req <= 1'b0;
                            flushed <= 1'b0;
                            state   <= ST_IDLE;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

`ifdef ICACHE_STATS_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            hit_count  <= '0;
            miss_count <= '0;
        end else begin
            if (hit) begin
                hit_count <= hit_count + 32'd1;
            end
            if (start_miss) begin
                miss_count <= miss_count + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_icache.sv
// Directed self-checking bench for icache with a backing memory that acks 2 cycles after each request.
module tb_icache;

    logic        clk = 1'b0;
    logic        reset;
    logic        cpu_req;
    logic [31:0] cpu_addr;
    logic        cpu_flush;
    logic [31:0] cpu_rdata;
    logic        cpu_stall;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack;
    logic [31:0] mem_rdata;
`ifdef ICACHE_STATS_EN
    logic [31:0] hit_count;
    logic [31:0] miss_count;
    logic [31:0] h0;
    logic [31:0] m0;
`endif

    int          errors = 0;
    int          checks = 0;
    int          age = 0;
    logic        ack_force;
    logic [31:0] acks [8];
    int          nack;

    typedef struct {
        logic        req;
        logic [31:0] addr;
        logic        stall;
        logic [31:0] rdata;
    } vec_t;
    vec_t tbl [6];

    always #5 clk = ~clk;

    icache dut (
        .clk        (clk),
        .reset      (reset),
        .cpu_req    (cpu_req),
        .cpu_addr   (cpu_addr),
        .cpu_flush  (cpu_flush),
        .cpu_rdata  (cpu_rdata),
        .cpu_stall  (cpu_stall),
        .mem_req    (mem_req),
        .mem_addr   (mem_addr),
        .mem_ack    (mem_ack),
        .mem_rdata  (mem_rdata)
`ifdef ICACHE_STATS_EN
        ,
        .hit_count  (hit_count),
        .miss_count (miss_count)
`endif
    );

    // Memory model: ack when a request has been held at one address for 2 cycles.
    always @(posedge clk) begin
        if (mem_req !== 1'b1 || mem_ack === 1'b1) age <= 0;
        else age <= age + 1;
    end
    assign mem_ack   = (mem_req === 1'b1 && age == 2) || ack_force;
    assign mem_rdata = mem_addr ^ 32'hA5A5_0000;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic do_fetch(input logic [31:0] a, input string name);
        logic [31:0] base;
        bit          done;
        base    = a & ~32'hF;
        cpu_req = 1'b1;
        cpu_addr = a;
        nack    = 0;
        done    = 1'b0;
        for (int n = 0; n < 80 && !done; n++) begin
            @(negedge clk);
            if (n == 0) check({name, " miss_stall"}, 32'(cpu_stall), 32'd1);
            if (!cpu_stall) begin
                done = 1'b1;
            end else begin
                if (mem_ack && nack < 8) begin
                    acks[nack] = mem_addr;
                    nack++;
                end
                @(posedge clk); #1;
            end
        end
        check({name, " completed"}, 32'(done), 32'd1);
        check({name, " beats"}, 32'(nack), 32'd4);
        for (int i = 0; i < 4; i++) check({name, " mem_addr"}, acks[i], base + 32'(4 * i));
        check({name, " rdata"}, cpu_rdata, a ^ 32'hA5A5_0000);
        check({name, " mem_req_idle"}, 32'(mem_req), 32'd0);
        @(posedge clk); #1;
    endtask

    task automatic seq_flush(input logic [31:0] a, input int flush_at, input string name);
        cpu_req  = 1'b1;
        cpu_addr = a;
        nack     = 0;
        for (int n = 0; n < 80 && nack < 4; n++) begin
            @(negedge clk);
            if (mem_ack) begin
                nack++;
                if (nack == flush_at) cpu_flush = 1'b1;
            end
            @(posedge clk); #1;
            cpu_flush = 1'b0;
        end
        check({name, " beats"}, 32'(nack), 32'd4);
        @(negedge clk);
        check({name, " still_miss"}, 32'(cpu_stall), 32'd1);
        check({name, " rdata0"}, cpu_rdata, 32'd0);
        @(posedge clk); #1;
    endtask

    initial begin
        reset     = 1'b1;
        cpu_req   = 1'b0;
        cpu_addr  = 32'd0;
        cpu_flush = 1'b0;
        ack_force = 1'b0;

        tbl[0] = '{1'b1, 32'h0000_0044, 1'b0, 32'hA5A5_0044};
        tbl[1] = '{1'b1, 32'h0000_0048, 1'b0, 32'hA5A5_0048};
        tbl[2] = '{1'b0, 32'h0000_0044, 1'b0, 32'h0000_0000};
        tbl[3] = '{1'b1, 32'h0000_004C, 1'b0, 32'hA5A5_004C};
        tbl[4] = '{1'b1, 32'h0000_0042, 1'b0, 32'hA5A5_0040};
        tbl[5] = '{1'b0, 32'h0000_1234, 1'b0, 32'h0000_0000};

        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("reset stall", 32'(cpu_stall), 32'd0);
        check("reset rdata", cpu_rdata, 32'd0);
        check("reset mem_req", 32'(mem_req), 32'd0);
        check("reset mem_addr", mem_addr, 32'd0);
        @(posedge clk); #1;

        // 1: cold miss and refill of line 0x40
        do_fetch(32'h40, "cold_0x40");
`ifdef ICACHE_STATS_EN
        check("miss_count after cold", miss_count, 32'd1);
        h0 = hit_count;
`endif

        // 2: same-cycle hits from the table
        for (int i = 0; i < 6; i++) begin
            cpu_req  = tbl[i].req;
            cpu_addr = tbl[i].addr;
            @(negedge clk);
            check($sformatf("tbl%0d stall", i), 32'(cpu_stall), 32'(tbl[i].stall));
            check($sformatf("tbl%0d rdata", i), cpu_rdata, tbl[i].rdata);
            check($sformatf("tbl%0d mem_req", i), 32'(mem_req), 32'd0);
            @(posedge clk); #1;
        end
        cpu_req = 1'b0;
`ifdef ICACHE_STATS_EN
        check("hit_count table delta", hit_count - h0, 32'd4);
`endif

        // 3: conflicting tag evicts line 4
        do_fetch(32'h440, "new_tag_0x440");
        do_fetch(32'h40, "evicted_0x40");

        // 4: flush during refill, and flush together with the final ack
        seq_flush(32'h80, 1, "flush_mid");
        do_fetch(32'h80, "after_flush_0x80");
        do_fetch(32'h440, "flushed_0x440");
        seq_flush(32'h40, 4, "flush_last");
        do_fetch(32'h40, "after_flush_last_0x40");

        // 5: reset in the middle of a refill
        cpu_req   = 1'b0;
        cpu_flush = 1'b1;
        @(posedge clk); #1;
        cpu_flush = 1'b0;
        cpu_req   = 1'b1;
        cpu_addr  = 32'h40;
        nack      = 0;
        for (int n = 0; n < 40 && nack < 2; n++) begin
            @(negedge clk);
            if (mem_ack) nack++;
            @(posedge clk); #1;
        end
        check("reset_mid acks before reset", 32'(nack), 32'd2);
        reset   = 1'b1;
        cpu_req = 1'b0;
        @(posedge clk); #1;
        reset     = 1'b0;
        ack_force = 1'b1;
        @(negedge clk);
        check("reset_mid mem_req", 32'(mem_req), 32'd0);
        check("reset_mid mem_addr", mem_addr, 32'd0);
        check("reset_mid stall", 32'(cpu_stall), 32'd0);
        @(posedge clk); #1;
        ack_force = 1'b0;
        @(negedge clk);
        check("late ack ignored mem_req", 32'(mem_req), 32'd0);
        check("late ack ignored mem_addr", mem_addr, 32'd0);
`ifdef ICACHE_STATS_EN
        check("reset hit_count", hit_count, 32'd0);
        check("reset miss_count", miss_count, 32'd0);
`endif
        @(posedge clk); #1;
        do_fetch(32'h40, "refetch_0x40");
`ifdef ICACHE_STATS_EN
        check("miss_count after refetch", miss_count, 32'd1);
`endif

        // 6: idle fetch with random address and stray acks
        cpu_req = 1'b0;
`ifdef ICACHE_STATS_EN
        h0 = hit_count;
        m0 = miss_count;
`endif
        for (int i = 0; i < 8; i++) begin
            cpu_addr  = $urandom & 32'h0000_0FFC;
            ack_force = 1'($urandom_range(0, 1));
            @(negedge clk);
            check($sformatf("idle%0d stall", i), 32'(cpu_stall), 32'd0);
            check($sformatf("idle%0d mem_req", i), 32'(mem_req), 32'd0);
            check($sformatf("idle%0d rdata", i), cpu_rdata, 32'd0);
            @(posedge clk); #1;
        end
        ack_force = 1'b0;
`ifdef ICACHE_STATS_EN
        check("idle hit_count", hit_count, h0);
        check("idle miss_count", miss_count, m0);
`endif
        cpu_req  = 1'b1;
        cpu_addr = 32'h48;
        @(negedge clk);
        check("post_idle hit stall", 32'(cpu_stall), 32'd0);
        check("post_idle hit rdata", cpu_rdata, 32'hA5A5_0048);
        @(posedge clk); #1;
        cpu_req = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
